// File: rtl/bus_arbiter_two_device.sv
// Round-robin arbiter for a two-device shared tristate bus with bounded hold
// time, a one-cycle turnaround between owners and registered bus capture.
module bus_arbiter_two_device #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req1,
  input  logic [N-1:0] data_in_1,
  output logic         gnt1,
  output logic [N-1:0] data_out_1,
  input  logic         req2,
  input  logic [N-1:0] data_in_2,
  output logic         gnt2,
  output logic [N-1:0] data_out_2,
  output logic         bus_valid
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN1, OWN2, TURN} state_t;

  state_t        state;
  state_t        arb_next;
  logic          last_owner;  // 0: device 1, 1: device 2
  logic [HW-1:0] hold_cnt;
  logic          release1;
  logic          release2;

  tri [N-1:0] bi_data;

  // Only the granted device drives the bus; grants are mutually exclusive.
  assign bi_data = gnt1 ? data_in_1 : (gnt2 ? data_in_2 : {N{1'bz}});

  // Arbitration used when leaving IDLE or TURN; ties go to the non-last owner.
  always_comb begin
    arb_next = IDLE;
    if (req1 && (!req2 || last_owner)) begin
      arb_next = OWN1;
    end else if (req2) begin
      arb_next = OWN2;
    end
  end

  assign release1 = !req1 || (req2 && (hold_cnt == HOLD_LAST));
  assign release2 = !req2 || (req1 && (hold_cnt == HOLD_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt1       <= 1'b0;
      gnt2       <= 1'b0;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
      data_out_1 <= '0;
      data_out_2 <= '0;
      bus_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE, TURN: begin
          state    <= arb_next;
          gnt1     <= (arb_next == OWN1);
          gnt2     <= (arb_next == OWN2);
          hold_cnt <= '0;
        end
        OWN1: begin
          if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + HW'(1);
          if (release1) begin
            state      <= TURN;
            gnt1       <= 1'b0;
            last_owner <= 1'b0;
          end
        end
        OWN2: begin
          if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + HW'(1);
          if (release2) begin
            state      <= TURN;
            gnt2       <= 1'b0;
            last_owner <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt1  <= 1'b0;
          gnt2  <= 1'b0;
        end
      endcase

      // Capture the bus only when it was actually driven during the last cycle.
      if (gnt1 || gnt2) begin
        data_out_1 <= bi_data;
        data_out_2 <= bi_data;
        bus_valid  <= 1'b1;
      end else begin
        bus_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_two_device.sv
// Directed bench for bus_arbiter_two_device: per-cycle expected outputs go
// through a scoreboard queue; a monitor checks grant exclusivity and turnaround.
module tb_bus_arbiter_two_device;

  logic       clk;
  logic       rst;
  logic       req1;
  logic       req2;
  logic [7:0] data_in_1;
  logic [7:0] data_in_2;
  logic       gnt1;
  logic       gnt2;
  logic [7:0] data_out_1;
  logic [7:0] data_out_2;
  logic       bus_valid;

  typedef struct packed {
    logic       g1;
    logic       g2;
    logic       v;
    logic [7:0] d1;
    logic [7:0] d2;
  } obs_t;

  obs_t exp_q[$];
  int   compared;
  int   mismatched;
  int   prev_owner;
  logic gap_seen;

  bus_arbiter_two_device #(.N(8), .MAX_HOLD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req1       (req1),
    .data_in_1  (data_in_1),
    .gnt1       (gnt1),
    .data_out_1 (data_out_1),
    .req2       (req2),
    .data_in_2  (data_in_2),
    .gnt2       (gnt2),
    .data_out_2 (data_out_2),
    .bus_valid  (bus_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the outputs expected after the edge, then compare.
  task automatic step(input string tag, input logic rs, input logic r1, input logic r2,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic eg1, input logic eg2, input logic ev, input logic [7:0] ed);
    obs_t e;
    obs_t got;
    rst       = rs;
    req1      = r1;
    req2      = r2;
    data_in_1 = a;
    data_in_2 = b;
    e = {eg1, eg2, ev, ed, ed};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {gnt1, gnt2, bus_valid, data_out_1, data_out_2};
    e = exp_q.pop_front();
    compared++;
    assert (got === e) else begin
      mismatched++;
      $error("FAIL %s: observed g1=%b g2=%b v=%b d1=%h d2=%h expected g1=%b g2=%b v=%b d=%h",
             tag, got.g1, got.g2, got.v, got.d1, got.d2, e.g1, e.g2, e.v, e.d1);
    end
  endtask

  // Grant exclusivity and at least one undriven cycle between different owners.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      compared++;
      assert ((gnt1 & gnt2) !== 1'b1) else begin
        mismatched++;
        $error("FAIL both_grants: observed gnt1=%b gnt2=%b expected not both 1", gnt1, gnt2);
      end
      if (gnt1 === 1'b1 || gnt2 === 1'b1) begin
        if (prev_owner != 0 && prev_owner != (gnt1 ? 1 : 2)) begin
          compared++;
          assert (gap_seen === 1'b1) else begin
            mismatched++;
            $error("FAIL turnaround: observed gap=%b expected gap=1 between owners %0d and %0d",
                   gap_seen, prev_owner, gnt1 ? 1 : 2);
          end
        end
        prev_owner = gnt1 ? 1 : 2;
        gap_seen   = 1'b0;
      end else begin
        gap_seen = 1'b1;
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    prev_owner = 0;
    gap_seen   = 1'b0;
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0; data_in_1 = 8'h00; data_in_2 = 8'h00;

    step("reset", 1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00);

    // Single owner: req1 for three cycles.
    step("sgl_grant", 0, 1, 0, 8'hAA, 8'h00, 1, 0, 0, 8'h00);
    for (int i = 0; i < 2; i++)
      step($sformatf("sgl_hold%0d", i), 0, 1, 0, 8'hAA, 8'h00, 1, 0, 1, 8'hAA);
    step("sgl_turn", 0, 0, 0, 8'hAA, 8'h00, 0, 0, 1, 8'hAA);
    step("sgl_idle0", 0, 0, 0, 8'hAA, 8'h00, 0, 0, 0, 8'hAA);
    step("sgl_idle1", 0, 0, 0, 8'hAA, 8'h00, 0, 0, 0, 8'hAA);

    // Tie after reset: forced release every MAX_HOLD cycles.
    step("tie_reset", 1, 0, 0, 8'hAA, 8'h55, 0, 0, 0, 8'h00);
    step("tie_own1", 0, 1, 1, 8'hAA, 8'h55, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++)
      step($sformatf("tie_hold1_%0d", i), 0, 1, 1, 8'hAA, 8'h55, 1, 0, 1, 8'hAA);
    step("tie_turn1", 0, 1, 1, 8'hAA, 8'h55, 0, 0, 1, 8'hAA);
    step("tie_own2", 0, 1, 1, 8'hAA, 8'h55, 0, 1, 0, 8'hAA);
    for (int i = 0; i < 3; i++)
      step($sformatf("tie_hold2_%0d", i), 0, 1, 1, 8'hAA, 8'h55, 0, 1, 1, 8'h55);
    step("tie_turn2", 0, 1, 1, 8'hAA, 8'h55, 0, 0, 1, 8'h55);
    step("tie_own1b", 0, 1, 1, 8'hAA, 8'h55, 1, 0, 0, 8'h55);
    step("tie_hold1b", 0, 1, 1, 8'hAA, 8'h55, 1, 0, 1, 8'hAA);
    step("tie_rel", 0, 0, 0, 8'hAA, 8'h55, 0, 0, 1, 8'hAA);
    step("tie_idle", 0, 0, 0, 8'hAA, 8'h55, 0, 0, 0, 8'hAA);

    // Lone requester keeps the bus past MAX_HOLD; data change mid-grant.
    step("lone_grant", 0, 0, 1, 8'hAA, 8'h3C, 0, 1, 0, 8'hAA);
    for (int i = 0; i < 3; i++)
      step($sformatf("lone_a%0d", i), 0, 0, 1, 8'hAA, 8'h3C, 0, 1, 1, 8'h3C);
    for (int i = 0; i < 6; i++)
      step($sformatf("lone_b%0d", i), 0, 0, 1, 8'hAA, 8'hC3, 0, 1, 1, 8'hC3);
    step("lone_turn", 0, 0, 0, 8'hAA, 8'hC3, 0, 0, 1, 8'hC3);
    step("lone_idle", 0, 0, 0, 8'hAA, 8'hC3, 0, 0, 0, 8'hC3);

    // Round-robin: tie presented in TURN after device 1 released.
    step("rr_own1", 0, 1, 0, 8'h5A, 8'hA5, 1, 0, 0, 8'hC3);
    step("rr_hold1", 0, 1, 0, 8'h5A, 8'hA5, 1, 0, 1, 8'h5A);
    step("rr_turn1", 0, 0, 0, 8'h5A, 8'hA5, 0, 0, 1, 8'h5A);
    step("rr_tie_own2", 0, 1, 1, 8'h5A, 8'hA5, 0, 1, 0, 8'h5A);
    step("rr_hold2", 0, 1, 1, 8'h5A, 8'hA5, 0, 1, 1, 8'hA5);
    step("rr_turn2", 0, 1, 0, 8'h5A, 8'hA5, 0, 0, 1, 8'hA5);
    step("rr_own1b", 0, 1, 0, 8'hAA, 8'hA5, 1, 0, 0, 8'hA5);
    step("rr_hold1b", 0, 1, 0, 8'hAA, 8'hA5, 1, 0, 1, 8'hAA);
    step("rr_turn3", 0, 0, 0, 8'hAA, 8'hA5, 0, 0, 1, 8'hAA);
    step("rr_own1c", 0, 1, 0, 8'hAA, 8'hA5, 1, 0, 0, 8'hAA);
    step("rr_hold1c", 0, 1, 0, 8'hAA, 8'hA5, 1, 0, 1, 8'hAA);

    // Reset mid-ownership; device 1 must win the next tie.
    step("mid_reset", 1, 1, 1, 8'hAA, 8'h55, 0, 0, 0, 8'h00);
    step("post_own1", 0, 1, 1, 8'hAA, 8'h55, 1, 0, 0, 8'h00);
    step("post_hold1", 0, 1, 1, 8'hAA, 8'h55, 1, 0, 1, 8'hAA);
    step("post_turn", 0, 0, 0, 8'hAA, 8'h55, 0, 0, 1, 8'hAA);
    step("post_idle", 0, 0, 0, 8'hAA, 8'h55, 0, 0, 0, 8'hAA);

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
